alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
Result/flag commit stage directly downstream of the 8051 ALU core. It captures the ALU's op_out_1/op_out_2 and flag outputs under a valid/ready handshake and commits them to the architectural ACC, B and PSW registers. It feeds CY and AC back to the ALU's carry_in/aux_carry_in. It also owns the SFR-bus read/write port for ACC (0xE0), B (0xF0) and PSW (0xD0).

Parameters:
ACC_ADDR, 8'hE0, SFR address of ACC
B_ADDR, 8'hF0, SFR address of B
PSW_ADDR, 8'hD0, SFR address of PSW

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
wb_valid  input  1  ALU result available for commit
wb_ready  output  1  stage can accept a result
wb_opcode  input  4  ALU opcode of the result (define_opcodes.v encodings)
wb_dest  input  2  00 ACC, 01 external, 10 flags only, 11 reserved (treated as 10)
wb_bit_op  input  1  ORL/ANL is a bit (C) operation
res_1  input  8  ALU op_out_1
res_2  input  8  ALU op_out_2
res_cy, res_ac, res_ov  input  1 each  ALU carry_out, aux_carry_out, overflow_out
wb_done  output  1  one-cycle pulse: commit completed
ext_we  output  1  one-cycle write strobe for wb_dest=01
ext_wdata  output  8  data for the external write
sfr_we  input  1  SFR write strobe
sfr_addr  input  8  SFR address
sfr_wdata  input  8  SFR write data
sfr_rdata  output  8  combinational read of ACC/B/PSW; 8'h00 otherwise
sfr_conflict  output  1  one-cycle pulse: SFR write lost to commit
acc  output  8  ACC register
b_reg  output  8  B register
psw  output  8  PSW {CY,AC,F0,RS1,RS0,OV,F1,P}
carry_flag  output  1  psw[7], to ALU carry_in
aux_flag  output  1  psw[6], to ALU aux_carry_in

Behaviour:
- Reset (reset=0, async): acc, b_reg, psw[7:1] = 0; state IDLE; wb_ready=1; wb_done, ext_we, sfr_conflict = 0. A captured result is discarded and never committed.
- P (psw[0]) is always the XOR of acc, derived from the registered acc; it cannot be written.
- FSM IDLE -> HOLD -> COMMIT -> IDLE.
  - IDLE: wb_ready=1. On wb_valid=1, latch opcode, dest, bit_op, results and flags; go to HOLD.
  - HOLD: wb_ready=0. Unconditionally go to COMMIT.
  - COMMIT: wb_ready=0. The rising edge leaving COMMIT updates registers. wb_done and ext_we pulse for exactly one cycle after that edge, coincident with IDLE.
- Latency: accept at edge N, registers visible after edge N+2, wb_done high in cycle N+2..N+3. Maximum throughput is one result per 3 cycles.
- Data commit:
  - MUL/DIV: acc<=res_1 and b_reg<=res_2, regardless of wb_dest.
  - ORL/ANL with wb_bit_op=1: no data write.
  - Otherwise dest 00 -> acc<=res_1. Dest 01 -> ext_wdata=res_1 with ext_we pulse. Dest 10/11 -> no data write.
- Flag commit:
  - ADD, ADDC, SUBB: CY, AC, OV updated from res_cy, res_ac, res_ov.
  - MUL, DIV: CY<=0, OV<=res_ov, AC unchanged.
  - RRC, RLC: CY<=res_cy.
  - ORL/ANL with wb_bit_op=1: CY<=res_cy.
  - INC, DEC, RR, RL, CPL, DA, SWAP, XRL, ORL/ANL byte: no flag change.
- SFR write, any state: applies at the next edge; a write to PSW ignores bit 0.
- SFR write in the COMMIT cycle targeting a register that the commit also writes: the commit wins and sfr_conflict pulses. PSW bits the commit does not touch still take the SFR value.
- wb_valid while not ready: ignored; upstream holds it. No queueing.

Test Plan:
- ADD: res_1=8'h00, res_cy=1, res_ac=1, res_ov=0, dest 00 -> acc=8'h00, psw=8'hC0, wb_done exactly 2 edges after accept.
- MUL: res_1=8'h50, res_2=8'h12, res_ov=1, prior CY=1 -> acc=8'h50, b_reg=8'h12, psw=8'h04.
- SFR write ACC=8'h07 while IDLE -> psw[0]=1, sfr_rdata at 8'hE0 reads 8'h07. SFR write PSW=8'hFF -> psw=8'hFF (P=1 from 8'h07, bit 0 of the write ignored).
- Backpressure: wb_valid held high for 6 cycles with two different results -> wb_ready 1,0,0,1,0,0; both committed in order; exactly two wb_done pulses.
- Conflict: SFR write ACC=8'h55 in the COMMIT cycle of INC with res_1=8'h12 -> acc=8'h12, sfr_conflict=1 for one cycle.
- Reset mid-operation: reset=0 during HOLD of ADD with res_1=8'h3C -> acc=8'h00, no wb_done, wb_ready=1 once reset releases.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Result handshake between the 8051 ALU and its writeback stage.
// The ALU side drives results; the stage returns ready/done/ext strobes.
interface alu_writeback_if;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_opcode;
    logic [1:0] wb_dest;
    logic       wb_bit_op;
    logic [7:0] res_1;
    logic [7:0] res_2;
    logic       res_cy;
    logic       res_ac;
    logic       res_ov;
    logic       wb_done;
    logic       ext_we;
    logic [7:0] ext_wdata;

    modport master (
        output wb_valid, wb_opcode, wb_dest, wb_bit_op,
        output res_1, res_2, res_cy, res_ac, res_ov,
        input  wb_ready, wb_done, ext_we, ext_wdata
    );

    modport slave (
        input  wb_valid, wb_opcode, wb_dest, wb_bit_op,
        input  res_1, res_2, res_cy, res_ac, res_ov,
        output wb_ready, wb_done, ext_we, ext_wdata
    );
endinterface

// File: rtl/alu_writeback.sv
// 8051 ALU result/flag commit stage owning ACC, B and PSW.
// Also serves the SFR read/write port for those three registers.
module alu_writeback #(
    parameter logic [7:0] ACC_ADDR = 8'hE0,
    parameter logic [7:0] B_ADDR   = 8'hF0,
    parameter logic [7:0] PSW_ADDR = 8'hD0
) (
    input  logic       clock,
    input  logic       reset,
    alu_writeback_if.slave wb,
    input  logic       sfr_we,
    input  logic [7:0] sfr_addr,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] sfr_rdata,
    output logic       sfr_conflict,
    output logic [7:0] acc,
    output logic [7:0] b_reg,
    output logic [7:0] psw,
    output logic       carry_flag,
    output logic       aux_flag
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDC = 4'h1;
    localparam logic [3:0] OP_SUBB = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_ANL  = 4'h9;
    localparam logic [3:0] OP_ORL  = 4'hA;
    localparam logic [3:0] OP_RLC  = 4'hD;
    localparam logic [3:0] OP_RRC  = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] op_q;
    logic [1:0] dest_q;
    logic       bit_q;
    logic [7:0] r1_q;
    logic [7:0] r2_q;
    logic       cy_q;
    logic       ac_q;
    logic       ov_q;

    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic [7:1] psw_hi;

    logic ready_q;
    logic done_q;
    logic ext_q;
    logic conf_q;

    logic       commit;
    logic       is_arith;
    logic       is_muldiv;
    logic       is_rot;
    logic       is_bitlog;
    logic       wr_acc;
    logic       wr_b;
    logic       wr_ext;
    logic       wr_cy;
    logic       wr_ac;
    logic       wr_ov;
    logic       sfr_acc;
    logic       sfr_b;
    logic       sfr_psw;
    logic       conflict;
    logic [7:0] acc_nxt;
    logic [7:0] b_nxt;
    logic [7:1] psw_nxt;

    always_comb begin
        commit    = (state == COMMIT);
        is_arith  = (op_q == OP_ADD) || (op_q == OP_ADDC)
                 || (op_q == OP_SUBB);
        is_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);
        is_rot    = (op_q == OP_RLC) || (op_q == OP_RRC);
        is_bitlog = bit_q && ((op_q == OP_ANL) || (op_q == OP_ORL));

        // dest 11 is reserved and falls through as flags-only
        wr_acc = commit && (is_muldiv
              || (!is_bitlog && dest_q == 2'b00));
        wr_b   = commit && is_muldiv;
        wr_ext = commit && !is_muldiv && !is_bitlog
              && (dest_q == 2'b01);
        wr_cy  = commit && (is_arith || is_muldiv
              || is_rot || is_bitlog);
        wr_ac  = commit && is_arith;
        wr_ov  = commit && (is_arith || is_muldiv);

        sfr_acc = sfr_we && (sfr_addr == ACC_ADDR);
        sfr_b   = sfr_we && (sfr_addr == B_ADDR);
        sfr_psw = sfr_we && (sfr_addr == PSW_ADDR);

        conflict = (sfr_acc && wr_acc) || (sfr_b && wr_b)
                || (sfr_psw && (wr_cy || wr_ac || wr_ov));

        acc_nxt = acc_q;
        if (wr_acc)
            acc_nxt = r1_q;
        else if (sfr_acc)
            acc_nxt = sfr_wdata;

        b_nxt = b_q;
        if (wr_b)
            b_nxt = r2_q;
        else if (sfr_b)
            b_nxt = sfr_wdata;

        // commit overrides only the flag bits it owns
        psw_nxt = sfr_psw ? sfr_wdata[7:1] : psw_hi;
        if (wr_cy)
            psw_nxt[7] = is_muldiv ? 1'b0 : cy_q;
        if (wr_ac)
            psw_nxt[6] = ac_q;
        if (wr_ov)
            psw_nxt[2] = ov_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            dest_q  <= '0;
            bit_q   <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
            cy_q    <= 1'b0;
            ac_q    <= 1'b0;
            ov_q    <= 1'b0;
            acc_q   <= '0;
            b_q     <= '0;
            psw_hi  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ext_q   <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_nxt;
            b_q    <= b_nxt;
            psw_hi <= psw_nxt;
            done_q <= commit;
            ext_q  <= wr_ext;
            conf_q <= conflict;
            unique case (state)
                IDLE: begin
                    if (wb.wb_valid) begin
                        op_q    <= wb.wb_opcode;
                        dest_q  <= wb.wb_dest;
                        bit_q   <= wb.wb_bit_op;
                        r1_q    <= wb.res_1;
                        r2_q    <= wb.res_2;
                        cy_q    <= wb.res_cy;
                        ac_q    <= wb.res_ac;
                        ov_q    <= wb.res_ov;
                        state   <= HOLD;
                        ready_q <= 1'b0;
                    end
                end
                HOLD: begin
                    state   <= COMMIT;
                    ready_q <= 1'b0;
                end
                COMMIT: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        sfr_rdata = 8'h00;
        if (sfr_addr == ACC_ADDR)
            sfr_rdata = acc;
        else if (sfr_addr == B_ADDR)
            sfr_rdata = b_q;
        else if (sfr_addr == PSW_ADDR)
            sfr_rdata = psw;
    end

    assign acc          = acc_q;
    assign b_reg        = b_q;
    assign psw          = {psw_hi, ^acc_q};
    assign carry_flag   = psw_hi[7];
    assign aux_flag     = psw_hi[6];
    assign sfr_conflict = conf_q;
    assign wb.wb_ready  = ready_q;
    assign wb.wb_done   = done_q;
    assign wb.ext_we    = ext_q;
    assign wb.ext_wdata = r1_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed scoreboard bench for the ALU writeback stage.
// Expected register state is queued at accept and checked on wb_done.
module tb_alu_writeback;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_INC = 4'h3;
    localparam logic [3:0] OP_DEC = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;
    localparam logic [3:0] OP_ANL = 4'h9;
    localparam logic [3:0] OP_ORL = 4'hA;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] b;
        logic [7:0] psw;
        logic       ext;
        logic [7:0] wdata;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       sfr_we;
    logic [7:0] sfr_addr;
    logic [7:0] sfr_wdata;
    logic [7:0] sfr_rdata;
    logic       sfr_conflict;
    logic [7:0] acc;
    logic [7:0] b_reg;
    logic [7:0] psw;
    logic       carry_flag;
    logic       aux_flag;

    alu_writeback_if wbi ();

    alu_writeback dut (
        .clock        (clock),
        .reset        (reset),
        .wb           (wbi.slave),
        .sfr_we       (sfr_we),
        .sfr_addr     (sfr_addr),
        .sfr_wdata    (sfr_wdata),
        .sfr_rdata    (sfr_rdata),
        .sfr_conflict (sfr_conflict),
        .acc          (acc),
        .b_reg        (b_reg),
        .psw          (psw),
        .carry_flag   (carry_flag),
        .aux_flag     (aux_flag)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ndone = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (wbi.wb_done === 1'b1) begin
            ndone++;
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_done obs=%0d exp=>0",
                       sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_acc", acc, e.acc);
                chk("sb_b", b_reg, e.b);
                chk("sb_psw", psw, e.psw);
                chk("sb_ext_we", {7'd0, wbi.ext_we}, {7'd0, e.ext});
                if (e.ext)
                    chk("sb_ext_wdata", wbi.ext_wdata, e.wdata);
            end
        end
    endtask

    task automatic drv(logic [3:0] op, logic [1:0] dst, logic bop,
                       logic [7:0] r1, logic [7:0] r2,
                       logic cy, logic ac, logic ov);
        wbi.wb_opcode = op;
        wbi.wb_dest   = dst;
        wbi.wb_bit_op = bop;
        wbi.res_1     = r1;
        wbi.res_2     = r2;
        wbi.res_cy    = cy;
        wbi.res_ac    = ac;
        wbi.res_ov    = ov;
    endtask

    task automatic push(logic [7:0] a, logic [7:0] b, logic [7:0] p,
                        logic x, logic [7:0] w);
        exp_t e;
        e.acc = a;
        e.b = b;
        e.psw = p;
        e.ext = x;
        e.wdata = w;
        sb.push_back(e);
    endtask

    task automatic sfr_wr(logic [7:0] a, logic [7:0] d);
        sfr_we = 1'b1;
        sfr_addr = a;
        sfr_wdata = d;
        tick();
        sfr_we = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (wbi.wb_done !== 1'b1 && n < 8);
    endtask

    task automatic run_op();
        int n;
        wbi.wb_valid = 1'b1;
        tick();
        wbi.wb_valid = 1'b0;
        wait_done(n);
        chk("done_seen", {7'd0, wbi.wb_done}, 8'd1);
    endtask

    initial begin
        int         n;
        int         k;
        int         d0;
        logic [5:0] pat;

        reset = 1'b0;
        sfr_we = 1'b0;
        sfr_addr = 8'h00;
        sfr_wdata = 8'h00;
        wbi.wb_valid = 1'b0;
        drv(OP_ADD, 2'b00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk("rst_acc", acc, 8'h00);
        chk("rst_b", b_reg, 8'h00);
        chk("rst_psw", psw, 8'h00);
        chk("rst_ready", {7'd0, wbi.wb_ready}, 8'd1);
        chk("rst_done", {7'd0, wbi.wb_done}, 8'd0);
        reset = 1'b1;
        tick();

        // ADD: latency check
        drv(OP_ADD, 2'b00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        wbi.wb_valid = 1'b1;
        push(8'h00, 8'h00, 8'hC0, 1'b0, 8'h00);
        tick();
        wbi.wb_valid = 1'b0;
        chk("add_ready_low", {7'd0, wbi.wb_ready}, 8'd0);
        wait_done(n);
        chk("add_latency", n[7:0], 8'd2);
        chk("add_cy_out", {6'd0, carry_flag, aux_flag}, 8'd3);
        tick();
        chk("done_pulse", {7'd0, wbi.wb_done}, 8'd0);

        // MUL with prior CY=1, AC=0
        sfr_wr(8'hD0, 8'h80);
        chk("sfr_psw80", psw, 8'h80);
        drv(OP_MUL, 2'b10, 1'b0, 8'h50, 8'h12, 1'b1, 1'b1, 1'b1);
        push(8'h50, 8'h12, 8'h04, 1'b0, 8'h00);
        run_op();

        // SFR writes while idle
        sfr_wr(8'hE0, 8'h07);
        chk("sfr_acc_psw", psw, 8'h05);
        sfr_addr = 8'hE0;
        #1 chk("rd_acc", sfr_rdata, 8'h07);
        sfr_wr(8'hD0, 8'hFF);
        chk("sfr_psw_ff", psw, 8'hFF);
        sfr_addr = 8'hF0;
        #1 chk("rd_b", sfr_rdata, 8'h12);
        sfr_addr = 8'h81;
        #1 chk("rd_other", sfr_rdata, 8'h00);

        // backpressure: valid held for six cycles
        pat = 6'b001001;
        k = 0;
        d0 = ndone;
        drv(OP_INC, 2'b00, 1'b0, 8'h21, 8'h00, 1'b1, 1'b1, 1'b1);
        wbi.wb_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("bp_ready", {7'd0, wbi.wb_ready}, {7'd0, pat[i]});
            if (wbi.wb_ready === 1'b1) begin
                if (k == 0)
                    push(8'h21, 8'h12, 8'hFE, 1'b0, 8'h00);
                else
                    push(8'h21, 8'h12, 8'hFE, 1'b1, 8'h34);
                k++;
            end
            if (i == 5)
                wbi.wb_valid = 1'b0;
            tick();
            if (i == 0)
                drv(OP_DEC, 2'b01, 1'b0, 8'h34, 8'h00,
                    1'b0, 1'b0, 1'b0);
        end
        wbi.wb_valid = 1'b0;
        chk("bp_dones", 8'(ndone - d0), 8'd2);

        // reserved dest and bit-op logic leave data alone
        drv(OP_ORL, 2'b11, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
        push(8'h21, 8'h12, 8'hFE, 1'b0, 8'h00);
        run_op();
        drv(OP_ANL, 2'b00, 1'b1, 8'h99, 8'h00, 1'b0, 1'b1, 1'b1);
        push(8'h21, 8'h12, 8'h7E, 1'b0, 8'h00);
        run_op();

        // SFR write to ACC loses to an INC commit
        drv(OP_INC, 2'b00, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0);
        push(8'h12, 8'h12, 8'h7E, 1'b0, 8'h00);
        wbi.wb_valid = 1'b1;
        tick();
        wbi.wb_valid = 1'b0;
        tick();
        sfr_wr(8'hE0, 8'h55);
        chk("conf_acc_pulse", {7'd0, sfr_conflict}, 8'd1);
        tick();
        chk("conf_acc_clear", {7'd0, sfr_conflict}, 8'd0);

        // PSW write during ADD commit: only untouched bits survive
        drv(OP_ADD, 2'b00, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
        push(8'h01, 8'h12, 8'h3D, 1'b0, 8'h00);
        wbi.wb_valid = 1'b1;
        tick();
        wbi.wb_valid = 1'b0;
        tick();
        sfr_wr(8'hD0, 8'h38);
        chk("conf_psw_pulse", {7'd0, sfr_conflict}, 8'd1);
        tick();

        // reset during HOLD discards the result
        drv(OP_ADD, 2'b00, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 1'b1);
        wbi.wb_valid = 1'b1;
        tick();
        wbi.wb_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_acc", acc, 8'h00);
        chk("mid_rst_ready", {7'd0, wbi.wb_ready}, 8'd1);
        chk("mid_rst_done", {7'd0, wbi.wb_done}, 8'd0);
        tick();
        reset = 1'b1;
        d0 = ndone;
        repeat (4) tick();
        chk("mid_rst_nodone", 8'(ndone - d0), 8'd0);
        chk("mid_rst_acc2", acc, 8'h00);
        chk("mid_rst_ready2", {7'd0, wbi.wb_ready}, 8'd1);
        chk("sb_drained", 8'(sb.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
